// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the instruction-fetch stage: word width,
// reset constants and the fetch FSM state encoding.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV32I_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] RV32I_NOP      = 32'h0000_0013;  // addi x0,x0,0

    // 2'd3 is unused; the FSM falls back to FETCH if it ever lands there.
    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_RSP = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the two low bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: PC-select mux loop, instruction-memory port and the
// decode-facing instruction slot.
interface if_fetch_unit_if;
    import rv32i_pkg::*;

    // PC-select mux loop
    logic            Redirect;
    logic [XLEN-1:0] Next_PC;
    logic [XLEN-1:0] PC_Plus4;

    // Instruction memory
    logic            IMEM_Req;
    logic [XLEN-1:0] IMEM_Addr;
    logic            IMEM_Gnt;
    logic            IMEM_Rvalid;
    logic [XLEN-1:0] IMEM_Rdata;

    // Decode slot
    logic            IF_Valid;
    logic [XLEN-1:0] IF_Instr;
    logic [XLEN-1:0] IF_PC;
    logic            ID_Ready;

    modport master (
        input  Redirect, Next_PC, IMEM_Gnt, IMEM_Rvalid, IMEM_Rdata, ID_Ready,
        output PC_Plus4, IMEM_Req, IMEM_Addr, IF_Valid, IF_Instr, IF_PC
    );

    modport slave (
        output Redirect, Next_PC, IMEM_Gnt, IMEM_Rvalid, IMEM_Rdata, ID_Ready,
        input  PC_Plus4, IMEM_Req, IMEM_Addr, IF_Valid, IF_Instr, IF_PC
    );

endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues one outstanding
// instruction-memory request at a time and fills a single valid/ready slot.
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RV32I_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = RV32I_NOP
) (
    input  logic            Clock,
    input  logic            Reset_n,
    if_fetch_unit_if.master bus
);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] pending_pc_reg, pending_pc_next;
    logic            valid_reg, valid_next;
    logic [XLEN-1:0] instr_reg, instr_next;
    logic [XLEN-1:0] if_pc_reg, if_pc_next;
    logic            fetch_req;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_reg      <= FETCH;
            pc_reg         <= align_pc(RESET_PC);
            pending_pc_reg <= '0;
            valid_reg      <= 1'b0;
            instr_reg      <= NOP_INSTR;
            if_pc_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pending_pc_reg <= pending_pc_next;
            valid_reg      <= valid_next;
            instr_reg      <= instr_next;
            if_pc_reg      <= if_pc_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        pending_pc_next = pending_pc_reg;
        valid_next      = valid_reg;
        instr_next      = instr_reg;
        if_pc_next      = if_pc_reg;
        fetch_req       = 1'b0;

        if (valid_reg && bus.ID_Ready) begin
            valid_next = 1'b0;
        end

        case (state_reg)
            FETCH: begin
                // Only request when the slot will be free to take the response.
                fetch_req = !bus.Redirect && (!valid_reg || bus.ID_Ready);
                if (bus.Redirect) begin
                    pc_next = align_pc(bus.Next_PC);
                end else if (fetch_req && bus.IMEM_Gnt) begin
                    pending_pc_next = pc_reg;
                    pc_next         = align_pc(bus.Next_PC);
                    state_next      = WAIT_RSP;
                end
            end

            WAIT_RSP: begin
                if (bus.IMEM_Rvalid && !bus.Redirect) begin
                    valid_next = 1'b1;
                    instr_next = bus.IMEM_Rdata;
                    if_pc_next = pending_pc_reg;
                    state_next = FETCH;
                end else if (bus.Redirect && !bus.IMEM_Rvalid) begin
                    pc_next    = align_pc(bus.Next_PC);
                    state_next = DISCARD;
                end else if (bus.Redirect && bus.IMEM_Rvalid) begin
                    pc_next    = align_pc(bus.Next_PC);
                    state_next = FETCH;
                end
            end

            DISCARD: begin
                // Stale response still in flight; swallow it before fetching again.
                if (bus.Redirect) begin
                    pc_next = align_pc(bus.Next_PC);
                end
                if (bus.IMEM_Rvalid) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        if (bus.Redirect) begin
            valid_next = 1'b0;
        end
    end

    assign bus.IMEM_Req  = Reset_n & fetch_req;
    assign bus.IMEM_Addr = pc_reg;
    assign bus.PC_Plus4  = pc_reg + 32'd4;
    assign bus.IF_Valid  = valid_reg;
    assign bus.IF_Instr  = instr_reg;
    assign bus.IF_PC     = if_pc_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a cycle-by-cycle vector table plus
// hand-written sequences for response latency and repeated redirects.
module tb_if_fetch_unit;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] target;

    if_fetch_unit_if bus ();

    if_fetch_unit dut (
        .Clock   (clk),
        .Reset_n (rst_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    // External PC-select mux, as in the core top.
    assign bus.Next_PC = bus.Redirect ? target : bus.PC_Plus4;

    typedef struct {
        logic        rst_n;
        logic        redir;
        logic [31:0] tgt;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NVEC = 33;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
    localparam logic [31:0] I0 = 32'h0010_0093, I1 = 32'h0020_0113, I2 = 32'h0030_0193;
    localparam logic [31:0] I3 = 32'h0040_0213, I4 = 32'h0050_0293, I5 = 32'h0060_0313;
    localparam logic [31:0] I6 = 32'h0070_0393, I7 = 32'h0080_0413, I8 = 32'h1234_5678;

    vec_t vecs [NVEC];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic r, input logic rd, input logic [31:0] t,
                                input logic g, input logic rv, input logic [31:0] d,
                                input logic y, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst_n = r;  v.redir = rd; v.tgt = t; v.gnt = g; v.rvalid = rv; v.rdata = d;
        v.rdy = y;    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev;
        v.exp_instr = ei; v.exp_pc = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] t, input logic g,
                         input logic rv, input logic [31:0] d, input logic y);
        rst_n = r; bus.Redirect = rd; target = t; bus.IMEM_Gnt = g;
        bus.IMEM_Rvalid = rv; bus.IMEM_Rdata = d; bus.ID_Ready = y;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waited;

        //          rst red tgt           gnt rv rdata rdy | req addr          vld instr pc
        vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0, 1,   0, 32'h0,        0, NOP, 32'h0);
        vecs[1]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, NOP, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0,        1, 1, I0,    1,   0, 32'h4,        0, NOP, 32'h0);
        vecs[3]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h4,        1, I0,  32'h0);
        vecs[4]  = mk(1, 0, 32'h0,        1, 1, I1,    1,   0, 32'h8,        0, I0,  32'h0);
        vecs[5]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h8,        1, I1,  32'h4);
        vecs[6]  = mk(1, 0, 32'h0,        1, 1, I2,    1,   0, 32'hC,        0, I1,  32'h4);
        vecs[7]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 0,   0, 32'hC,        1, I2,  32'h8);
        vecs[8]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 0,   0, 32'hC,        1, I2,  32'h8);
        vecs[9]  = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'hC,        1, I2,  32'h8);
        vecs[10] = mk(1, 1, 32'h100,      1, 0, 32'h0, 1,   0, 32'h10,       0, I2,  32'h8);
        vecs[11] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h100,      0, I2,  32'h8);
        vecs[12] = mk(1, 0, 32'h0,        1, 1, JUNK,  1,   0, 32'h100,      0, I2,  32'h8);
        vecs[13] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h100,      0, I2,  32'h8);
        vecs[14] = mk(1, 0, 32'h0,        1, 1, I3,    1,   0, 32'h104,      0, I2,  32'h8);
        vecs[15] = mk(1, 0, 32'h0,        0, 0, 32'h0, 1,   1, 32'h104,      1, I3,  32'h100);
        vecs[16] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h104,      0, I3,  32'h100);
        vecs[17] = mk(1, 1, 32'h200,      1, 1, JUNK,  1,   0, 32'h108,      0, I3,  32'h100);
        vecs[18] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h200,      0, I3,  32'h100);
        vecs[19] = mk(1, 0, 32'h0,        1, 1, I4,    1,   0, 32'h204,      0, I3,  32'h100);
        vecs[20] = mk(1, 1, 32'h103,      1, 0, 32'h0, 0,   0, 32'h204,      1, I4,  32'h200);
        vecs[21] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h100,      0, I4,  32'h200);
        vecs[22] = mk(1, 0, 32'h0,        1, 1, I5,    1,   0, 32'h104,      0, I4,  32'h200);
        vecs[23] = mk(1, 1, 32'hFFFFFFFC, 1, 0, 32'h0, 1,   0, 32'h104,      1, I5,  32'h100);
        vecs[24] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'hFFFFFFFC, 0, I5,  32'h100);
        vecs[25] = mk(1, 0, 32'h0,        1, 1, I6,    1,   0, 32'h0,        0, I5,  32'h100);
        vecs[26] = mk(1, 0, 32'h0,        0, 0, 32'h0, 1,   1, 32'h0,        1, I6,  32'hFFFFFFFC);
        vecs[27] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, I6,  32'hFFFFFFFC);
        vecs[28] = mk(0, 0, 32'h0,        1, 0, 32'h0, 1,   0, 32'h4,        0, I6,  32'hFFFFFFFC);
        vecs[29] = mk(1, 0, 32'h0,        0, 1, JUNK,  1,   1, 32'h0,        0, NOP, 32'h0);
        vecs[30] = mk(1, 0, 32'h0,        1, 0, 32'h0, 1,   1, 32'h0,        0, NOP, 32'h0);
        vecs[31] = mk(1, 0, 32'h0,        1, 1, I7,    1,   0, 32'h4,        0, NOP, 32'h0);
        vecs[32] = mk(1, 0, 32'h0,        1, 0, 32'h0, 0,   0, 32'h4,        1, I7,  32'h0);

        // Preamble: one reset edge so every register holds a known value.
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        step();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst_n, vecs[i].redir, vecs[i].tgt, vecs[i].gnt,
                  vecs[i].rvalid, vecs[i].rdata, vecs[i].rdy);
            #2;
            $display("[TB] vec %0d req=%b addr=%h valid=%b instr=%h pc=%h",
                     i, bus.IMEM_Req, bus.IMEM_Addr, bus.IF_Valid, bus.IF_Instr, bus.IF_PC);
            check($sformatf("v%0d req", i),    {31'b0, bus.IMEM_Req}, {31'b0, vecs[i].exp_req});
            check($sformatf("v%0d addr", i),   bus.IMEM_Addr, vecs[i].exp_addr);
            check($sformatf("v%0d plus4", i),  bus.PC_Plus4, vecs[i].exp_addr + 32'd4);
            check($sformatf("v%0d valid", i),  {31'b0, bus.IF_Valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d instr", i),  bus.IF_Instr, vecs[i].exp_instr);
            check($sformatf("v%0d if_pc", i),  bus.IF_PC, vecs[i].exp_pc);
            step();
        end

        // Latency: grant at n, Rvalid at n+3 -> IF_Valid at n+4.
        drive(1, 0, 32'h0, 1, 0, 32'h0, 1);
        #2;
        check("lat req", {31'b0, bus.IMEM_Req}, 32'd1);
        check("lat addr", bus.IMEM_Addr, 32'h4);
        step();
        for (int c = 0; c < 2; c++) begin
            drive(1, 0, 32'h0, 0, 0, 32'h0, 1);
            #2;
            check($sformatf("lat wait%0d req", c), {31'b0, bus.IMEM_Req}, 32'd0);
            step();
        end
        drive(1, 0, 32'h0, 0, 1, I8, 1);
        #2;
        check("lat pre-valid", {31'b0, bus.IF_Valid}, 32'd0);
        step();
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0);
        waited = 0;
        while (!bus.IF_Valid && waited < 8) begin
            step();
            waited++;
        end
        $display("[TB] latency seq waited=%0d instr=%h pc=%h", waited, bus.IF_Instr, bus.IF_PC);
        check("lat extra cycles", waited, 32'd0);
        check("lat instr", bus.IF_Instr, I8);
        check("lat if_pc", bus.IF_PC, 32'h4);

        // Two redirects while discarding: the later target wins.
        drive(1, 0, 32'h0, 1, 0, 32'h0, 1);
        #2;
        check("disc req", {31'b0, bus.IMEM_Req}, 32'd1);
        check("disc addr", bus.IMEM_Addr, 32'h8);
        step();
        drive(1, 1, 32'h300, 0, 0, 32'h0, 1);
        step();
        drive(1, 1, 32'h400, 1, 0, 32'h0, 1);
        #2;
        check("disc2 req", {31'b0, bus.IMEM_Req}, 32'd0);
        check("disc2 addr", bus.IMEM_Addr, 32'h300);
        step();
        drive(1, 0, 32'h0, 1, 1, JUNK, 1);
        #2;
        check("disc rsp req", {31'b0, bus.IMEM_Req}, 32'd0);
        check("disc rsp addr", bus.IMEM_Addr, 32'h400);
        step();
        drive(1, 0, 32'h0, 0, 0, 32'h0, 1);
        #2;
        $display("[TB] discard seq req=%b addr=%h valid=%b", bus.IMEM_Req, bus.IMEM_Addr, bus.IF_Valid);
        check("disc refetch req", {31'b0, bus.IMEM_Req}, 32'd1);
        check("disc refetch addr", bus.IMEM_Addr, 32'h400);
        check("disc dropped valid", {31'b0, bus.IF_Valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the RV32I core.
- Owns the fetch PC register and drives PC+4 to the PC-select 2:1 mux.
- Consumes that mux's output as the next PC. The mux select is Redirect, driven by the branch/jump unit.
- Issues single-outstanding requests to instruction memory and presents fetched instructions to decode through a valid/ready register slot.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
NOP_INSTR, 32'h0000_0013, IF_Instr value after reset (addi x0,x0,0)

Ports:
Clock  in  1  single core clock, rising edge
Reset_n  in  1  synchronous, active-low reset
Redirect  in  1  branch/jump taken; also the PC-select mux select
Next_PC  in  32  PC-select mux output (PC_Plus4 or target)
PC_Plus4  out  32  combinational fetch PC + 4, to mux input A
IMEM_Req  out  1  fetch request
IMEM_Addr  out  32  fetch address (= fetch PC)
IMEM_Gnt  in  1  request accepted this cycle
IMEM_Rvalid  in  1  read data valid, earliest 1 cycle after grant
IMEM_Rdata  in  32  instruction word
IF_Valid  out  1  instruction slot holds a valid instruction
IF_Instr  out  32  instruction to decode
IF_PC  out  32  PC of IF_Instr
ID_Ready  in  1  decode accepts slot this cycle

Behaviour:
- Reset (Reset_n=0 at posedge):
  - PC=RESET_PC, state=FETCH, IF_Valid=0, IF_Instr=NOP_INSTR, IF_PC=0, Pending_PC=0.
  - IMEM_Req=0 during any cycle with Reset_n=0.
- Reset mid-transaction: a pending response is abandoned. Rvalid arriving in FETCH is ignored.
- Registers: PC[31:0]; Pending_PC[31:0]; state in {FETCH, WAIT_RSP, DISCARD}; output slot {IF_Valid, IF_Instr, IF_PC}.
- Address rules:
  - PC[1:0] forced to 00 on every load (Next_PC[1:0] ignored).
  - PC_Plus4 = PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- FETCH:
  - IMEM_Req = Reset_n & ~Redirect & (~IF_Valid | ID_Ready); IMEM_Addr = PC.
  - Req&Gnt: Pending_PC<=PC, PC<=Next_PC (equals PC_Plus4 since Redirect=0), ->WAIT_RSP.
  - Redirect: no request; PC<=Next_PC; stay FETCH.
- WAIT_RSP:
  - IMEM_Req=0.
  - Rvalid & ~Redirect: IF_Valid<=1, IF_Instr<=Rdata, IF_PC<=Pending_PC, ->FETCH.
  - Redirect & ~Rvalid: PC<=Next_PC, ->DISCARD.
  - Redirect & Rvalid (same cycle): response dropped, PC<=Next_PC, ->FETCH.
- DISCARD:
  - IMEM_Req=0.
  - Rvalid: response dropped, ->FETCH.
  - Redirect: PC<=Next_PC (last redirect wins), stay DISCARD.
- Output slot:
  - IF_Valid & ID_Ready with no fill in that cycle -> IF_Valid<=0.
  - Redirect -> IF_Valid<=0 next cycle regardless of ID_Ready (flush). IF_Instr/IF_PC hold.
  - Slot invariant: a request is issued only when the slot is empty or draining, so the slot is empty whenever a response is accepted. No skid storage is needed.
- Latency: Gnt at cycle n, Rvalid at n+k (k≥1) -> IF_Valid at n+k+1.
- Peak throughput: one instruction per 2 cycles with k=1 and Gnt tied high.
- At most one outstanding request at any time.

Decomposition:
- rv32i_pkg holds:
  - NOP_INSTR constant and default RESET_PC
  - XLEN=32
  - fetch state encoding: FETCH=2'd0, WAIT_RSP=2'd1, DISCARD=2'd2; 2'd3 illegal, recovers to FETCH
- No sub-module. The PC-select mux stays outside, instantiated in the core top between this block and the branch unit.

Test Plan:
- Reset, then Reset_n=1, Gnt=1, 1-cycle memory, ID_Ready=1 -> IMEM_Addr 0x0,0x4,0x8 in successive request cycles; IF_PC/IF_Instr match; IF_Valid pulses every 2nd cycle.
- ID_Ready=0 after first instruction -> IF_Valid held high, IF_Instr stable, IMEM_Req=0; ID_Ready=1 -> next request at 0x4 that same cycle.
- Redirect to 0x100 one cycle after grant of 0x8, Rvalid 2 cycles later -> 0x8 data dropped (never IF_Valid), next IMEM_Addr=0x100, IF_PC=0x100.
- Redirect and Rvalid in same cycle, Next_PC=0x200 -> no IF_Valid for that data, next request 0x200.
- Next_PC=0x0000_0103 on Redirect -> IMEM_Addr=0x100. PC=0xFFFF_FFFC -> PC_Plus4=0x0.
- Reset_n=0 asserted in WAIT_RSP, Rvalid arrives after release -> ignored; first request at RESET_PC; IF_Instr=0x0000_0013, IF_Valid=0.
